// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - CLINT mtime/mtimecmp/msip block; CLINT_MTIME_SNAPSHOT_EN adds an atomic mtime hi snapshot
module clint_timer #(
    parameter int unsigned PRESCALE    = 1,
    parameter logic [63:0] MTIME_RESET = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        CS_L,
    input  logic        WE_L,
    input  logic [4:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        irq_software,
    output logic        irq_timer
);

    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

    logic [15:0] prescale_count;
    logic        tick;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;

    logic [4:0]  offset;
    logic        wr_en;
    logic        wr_msip;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;

    // Byte-lane bits are masked off so decode works on word offsets only.
    assign offset      = address & 5'b11100;
    assign wr_en       = !CS_L && !WE_L;
    assign wr_msip     = wr_en && (offset == 5'h00);
    assign wr_cmp_lo   = wr_en && (offset == 5'h08);
    assign wr_cmp_hi   = wr_en && (offset == 5'h0C);
    assign wr_mtime_lo = wr_en && (offset == 5'h10);
    assign wr_mtime_hi = wr_en && (offset == 5'h14);

    assign tick = (prescale_count == PRESCALE_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescale_count <= 16'h0;
        end else if (tick) begin
            prescale_count <= 16'h0;
        end else begin
            prescale_count <= prescale_count + 16'h1;
        end
    end

    // A write to either half suppresses the tick entirely, so no carry leaks across halves.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mtime <= MTIME_RESET;
        end else if (wr_mtime_lo) begin
            mtime[31:0] <= write_data;
        end else if (wr_mtime_hi) begin
            mtime[63:32] <= write_data;
        end else if (tick) begin
            mtime <= mtime + 64'h1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            if (wr_cmp_lo) begin
                mtimecmp[31:0] <= write_data;
            end
            if (wr_cmp_hi) begin
                mtimecmp[63:32] <= write_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            msip      <= 1'b0;
            irq_timer <= 1'b0;
        end else begin
            if (wr_msip) begin
                msip <= write_data[0];
            end
            irq_timer <= (mtime >= mtimecmp);
        end
    end

    assign irq_software = msip;

`ifdef CLINT_MTIME_SNAPSHOT_EN
    logic        rd_mtime_lo;
    logic [31:0] mtime_hi_snap;

    assign rd_mtime_lo = !CS_L && WE_L && (offset == 5'h10);

    // Reading the low half freezes the high half so a lo-then-hi pair is atomic.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mtime_hi_snap <= MTIME_RESET[63:32];
        end else if (wr_mtime_hi) begin
            mtime_hi_snap <= write_data;
        end else if (rd_mtime_lo) begin
            mtime_hi_snap <= mtime[63:32];
        end
    end
`endif

    always_comb begin
        read_data = 32'h0;
        if (!CS_L) begin
            case (offset)
                5'h00:   read_data = {31'h0, msip};
                5'h08:   read_data = mtimecmp[31:0];
                5'h0C:   read_data = mtimecmp[63:32];
                5'h10:   read_data = mtime[31:0];
`ifdef CLINT_MTIME_SNAPSHOT_EN
                5'h14:   read_data = mtime_hi_snap;
`else
                5'h14:   read_data = mtime[63:32];
`endif
                default: read_data = 32'h0;
            endcase
        end
    end

endmodule
